// File: rtl/conv_mac_sequencer.sv
// Sequencer for the shared 16x16 multiplier: walks a kernel window one tap per clock,
// bit-reverses each returned product and accumulates the dot product onto a valid/ready port.
module conv_mac_sequencer #(
  parameter int unsigned TAP_W  = 5,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TAP_W-1:0]  num_taps,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] k_base,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr_x,
  output logic [ADDR_W-1:0] mem_addr_k,
  input  logic [15:0]       x_data,
  input  logic [15:0]       k_data,
  output logic [15:0]       mul_a,
  output logic [15:0]       mul_b,
  input  logic [31:0]       mul_r,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int unsigned PROD_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [TAP_W-1:0]    ntaps_q, ntaps_d;
  logic [TAP_W-1:0]    idx_q, idx_d;
  logic                drain_q, drain_d;
  logic [ADDR_W-1:0]   addr_x_q, addr_x_d;
  logic [ADDR_W-1:0]   addr_k_q, addr_k_d;
  logic                rd_en_q, rd_en_d;
  logic                dv_q, dv_d;
  logic                mv_q, mv_d;
  logic [15:0]         mul_a_q, mul_a_d;
  logic [15:0]         mul_b_q, mul_b_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [PROD_W-1:0]   prod;

  // Undo the multiplier's bit-reversed product bus
  always_comb begin
    prod = '0;
    for (int i = 0; i < int'(PROD_W); i++) begin
      prod[i] = mul_r[PROD_W-1-i];
    end
  end

  always_comb begin
    state_d  = state_q;
    ntaps_d  = ntaps_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    addr_x_d = addr_x_q;
    addr_k_d = addr_k_q;
    rd_en_d  = 1'b0;
    // dv: read data on the bus this cycle; mv: mul_a/mul_b hold a live tap
    dv_d     = rd_en_q;
    mv_d     = dv_q;
    mul_a_d  = dv_q ? x_data : mul_a_q;
    mul_b_d  = dv_q ? k_data : mul_b_q;
    acc_d    = mv_q ? acc_q + ACC_W'(prod) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ntaps_d  = num_taps;
          idx_d    = '0;
          acc_d    = '0;
          addr_x_d = x_base;
          addr_k_d = k_base;
          if (num_taps == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            rd_en_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if ((idx_q + TAP_W'(1)) == ntaps_q) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          rd_en_d  = 1'b1;
          idx_d    = idx_q + TAP_W'(1);
          addr_x_d = addr_x_q + ADDR_W'(1);
          addr_k_d = addr_k_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d = S_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ntaps_q  <= '0;
      idx_q    <= '0;
      drain_q  <= 1'b0;
      addr_x_q <= '0;
      addr_k_q <= '0;
      rd_en_q  <= 1'b0;
      dv_q     <= 1'b0;
      mv_q     <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ntaps_q  <= ntaps_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      addr_x_q <= addr_x_d;
      addr_k_q <= addr_k_d;
      rd_en_q  <= rd_en_d;
      dv_q     <= dv_d;
      mv_q     <= mv_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_addr_x   = addr_x_q;
  assign mem_addr_k   = addr_k_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign result       = acc_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer with registered operand memories and a
// bit-reversing multiplier model; cycle k means the period after the k-th edge from start.
module tb_conv_mac_sequencer;

  localparam int unsigned TAP_W  = 5;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned ACC_W  = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [TAP_W-1:0]  num_taps;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] k_base;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr_x;
  logic [ADDR_W-1:0] mem_addr_k;
  logic [15:0]       x_data;
  logic [15:0]       k_data;
  logic [15:0]       mul_a;
  logic [15:0]       mul_b;
  logic [31:0]       mul_r;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;

  logic [15:0] xmem [256];
  logic [15:0] kmem [256];

  int errors = 0;
  int checks = 0;

  conv_mac_sequencer #(.TAP_W(TAP_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_taps(num_taps),
    .x_base(x_base), .k_base(k_base), .busy(busy), .mem_rd_en(mem_rd_en),
    .mem_addr_x(mem_addr_x), .mem_addr_k(mem_addr_k), .x_data(x_data),
    .k_data(k_data), .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  assign mul_r = rev32(32'(mul_a) * 32'(mul_b));

  always @(posedge clk) begin
    if (mem_rd_en) begin
      x_data <= xmem[mem_addr_x];
      k_data <= kmem[mem_addr_k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_rden"},  64'(mem_rd_en), 64'd0);
    check({tag, "_addrx"}, 64'(mem_addr_x), 64'd0);
    check({tag, "_addrk"}, 64'(mem_addr_k), 64'd0);
    check({tag, "_mula"},  64'(mul_a), 64'd0);
    check({tag, "_mulb"},  64'(mul_b), 64'd0);
    check({tag, "_res"},   64'(result), 64'd0);
    check({tag, "_valid"}, 64'(result_valid), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      xmem[i] = 16'h0;
      kmem[i] = 16'h0;
    end
    x_data = '0; k_data = '0;
    rst_n = 1'b0; start = 1'b0; num_taps = '0; x_base = '0; k_base = '0;
    result_ready = 1'b0;
    tick(); tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Single tap: 3*5
    xmem[0] = 16'd3; kmem[0] = 16'd5;
    start = 1'b1; num_taps = 5'd1; x_base = 8'd0; k_base = 8'd0;
    tick();  // cycle 1
    start = 1'b0;
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_rden_c1", 64'(mem_rd_en), 64'd1);
    tick();  // cycle 2
    check("t1_rden_c2", 64'(mem_rd_en), 64'd0);
    tick();  // cycle 3
    check("t1_mula", 64'(mul_a), 64'd3);
    check("t1_mulb", 64'(mul_b), 64'd5);
    check("t1_valid_c3", 64'(result_valid), 64'd0);
    tick();  // cycle 4
    check("t1_valid_c4", 64'(result_valid), 64'd1);
    check("t1_result", 64'(result), 64'd15);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("t1_valid_after", 64'(result_valid), 64'd0);
    check("t1_busy_after", 64'(busy), 64'd0);

    // Four taps, with a stray start mid-run and 10 cycles of backpressure
    xmem[0] = 16'd1;  xmem[1] = 16'd2;  xmem[2] = 16'd3;  xmem[3] = 16'd4;
    kmem[0] = 16'd10; kmem[1] = 16'd20; kmem[2] = 16'd30; kmem[3] = 16'd40;
    start = 1'b1; num_taps = 5'd4; x_base = 8'd0; k_base = 8'd0;
    tick();  // cycle 1
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_rden", 64'(mem_rd_en), 64'd1);
      check("t4_addrx", 64'(mem_addr_x), 64'(i));
      check("t4_addrk", 64'(mem_addr_k), 64'(i));
      if (i == 0) begin
        start = 1'b1; num_taps = 5'd7; x_base = 8'd50; k_base = 8'd60;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("t4_rden_c5", 64'(mem_rd_en), 64'd0);
    tick();  // cycle 6
    check("t4_valid_c6", 64'(result_valid), 64'd0);
    tick();  // cycle 7
    check("t4_valid_c7", 64'(result_valid), 64'd1);
    check("t4_result", 64'(result), 64'd300);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      check("bp_valid", 64'(result_valid), 64'd1);
      check("bp_result", 64'(result), 64'd300);
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("bp_valid_after", 64'(result_valid), 64'd0);
    check("bp_busy_after", 64'(busy), 64'd0);

    // 31 taps of 0xFFFF with sample address wrap
    for (int i = 0; i < 256; i++) begin
      xmem[i] = 16'hFFFF;
      kmem[i] = 16'hFFFF;
    end
    start = 1'b1; num_taps = 5'd31; x_base = 8'hF0; k_base = 8'h10;
    tick();  // cycle 1
    start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      check("max_rden", 64'(mem_rd_en), 64'd1);
      check("max_addrx", 64'(mem_addr_x), 64'((8'hF0 + i) % 256));
      tick();
    end
    check("max_rden_end", 64'(mem_rd_en), 64'd0);
    tick();  // cycle 33
    check("max_valid_c33", 64'(result_valid), 64'd0);
    tick();  // cycle 34
    check("max_valid_c34", 64'(result_valid), 64'd1);
    check("max_result", 64'(result), 64'h1E_FFC2_001F);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Zero taps
    start = 1'b1; num_taps = 5'd0; x_base = 8'd5; k_base = 8'd6;
    tick();  // cycle 1
    start = 1'b0;
    check("z_valid", 64'(result_valid), 64'd1);
    check("z_result", 64'(result), 64'd0);
    check("z_rden", 64'(mem_rd_en), 64'd0);
    check("z_busy", 64'(busy), 64'd1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("z_valid_after", 64'(result_valid), 64'd0);

    // Reset during tap 2 of 8, then a 2-tap run
    start = 1'b1; num_taps = 5'd8; x_base = 8'd0; k_base = 8'd0;
    tick();  // tap 0
    start = 1'b0;
    tick();  // tap 1
    tick();  // tap 2
    check("rst_rden_pre", 64'(mem_rd_en), 64'd1);
    rst_n = 1'b0;
    tick();
    check_reset_vals("midrst");
    rst_n = 1'b1;
    tick();
    xmem[8'h20] = 16'd2; xmem[8'h21] = 16'd3;
    kmem[8'h40] = 16'd4; kmem[8'h41] = 16'd5;
    start = 1'b1; num_taps = 5'd2; x_base = 8'h20; k_base = 8'h40;
    tick();  // cycle 1
    start = 1'b0;
    check("r2_addrk", 64'(mem_addr_k), 64'h40);
    tick(); tick(); tick();  // cycle 4
    check("r2_valid_c4", 64'(result_valid), 64'd0);
    tick();  // cycle 5
    check("r2_valid_c5", 64'(result_valid), 64'd1);
    check("r2_result", 64'(result), 64'd23);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("r2_busy_after", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
